// File: rtl/keystream_lfsr_gen_if.sv
// Keystream handshake bus between the LFSR generator (master) and the
// downstream XOR scrambler stage (slave).
interface keystream_lfsr_gen_if #(
  parameter int unsigned WIDTH = 6
) ();

  logic             ks_valid;
  logic             ks_ready;
  logic [WIDTH-1:0] ks_data;

  modport master (
    output ks_valid,
    output ks_data,
    input  ks_ready
  );

  modport slave (
    input  ks_valid,
    input  ks_data,
    output ks_ready
  );

endinterface

// File: rtl/keystream_lfsr_gen.sv
// keystream_lfsr_gen: Galois-LFSR keystream source for the XOR scrambler.
// Produces one WIDTH-bit word per accepted transfer, WIDTH LFSR steps per
// word unrolled into a single cycle.
// Optional feature macro: KS_WORD_COUNT_EN adds the ks_count output, a
// 16-bit wrapping count of accepted words.
module keystream_lfsr_gen #(
  parameter int unsigned            WIDTH    = 6,
  parameter int unsigned            LFSR_LEN = 16,
  parameter logic [LFSR_LEN-1:0]    TAPS     = 16'hB400,
  parameter logic [LFSR_LEN-1:0]    SEED_RST = 16'h0001
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      seed_load,
  input  logic [LFSR_LEN-1:0]       seed,
  input  logic                      start,
  input  logic                      stop,
  keystream_lfsr_gen_if.master      ks,
  output logic                      busy,
`ifdef KS_WORD_COUNT_EN
  output logic [15:0]               ks_count,
`endif
  output logic                      seed_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t              state;
  logic [LFSR_LEN-1:0] lfsr;
  logic [LFSR_LEN-1:0] step_s;
  logic [LFSR_LEN-1:0] next_lfsr_c;
  logic [WIDTH-1:0]    next_word_c;
  logic                accept_c;

  // Unrolled WIDTH-step Galois advance; word bit i is s[0] before step i.
  always_comb begin
    step_s      = lfsr;
    next_word_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      next_word_c[i] = step_s[0];
      if (step_s[0]) begin
        step_s = (step_s >> 1) ^ TAPS;
      end else begin
        step_s = step_s >> 1;
      end
    end
    next_lfsr_c = step_s;
  end

  assign accept_c = ks.ks_valid && ks.ks_ready;

  // Control FSM with registered handshake, status and LFSR state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lfsr        <= SEED_RST;
      ks.ks_valid <= 1'b0;
      ks.ks_data  <= '0;
      busy        <= 1'b0;
      seed_err    <= 1'b0;
`ifdef KS_WORD_COUNT_EN
      ks_count    <= '0;
`endif
    end else begin
      seed_err <= 1'b0;
`ifdef KS_WORD_COUNT_EN
      if (accept_c) begin
        ks_count <= ks_count + 16'd1;
      end
`endif
      case (state)
        IDLE: begin
          // A zero seed would lock the LFSR at zero, so it is refused.
          if (seed_load) begin
            if (seed != '0) begin
              lfsr <= seed;
`ifdef KS_WORD_COUNT_EN
              ks_count <= '0;
`endif
            end else begin
              seed_err <= 1'b1;
            end
          end
          if (start) begin
            state <= PRIME;
            busy  <= 1'b1;
          end
        end

        PRIME: begin
          ks.ks_data  <= next_word_c;
          lfsr        <= next_lfsr_c;
          ks.ks_valid <= 1'b1;
          state       <= RUN;
        end

        RUN: begin
          if (stop) begin
            if (ks.ks_ready) begin
              ks.ks_valid <= 1'b0;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end else if (accept_c) begin
            // Refill on the accepting edge so there is no bubble.
            ks.ks_data <= next_word_c;
            lfsr       <= next_lfsr_c;
          end
        end

        DRAIN: begin
          if (ks.ks_ready) begin
            ks.ks_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          ks.ks_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keystream_lfsr_gen.sv
// Bench for keystream_lfsr_gen: directed stimulus feeds an expected-word
// queue; a negedge monitor pops and compares on every accepted transfer.
module tb_keystream_lfsr_gen;

  localparam int unsigned WIDTH    = 6;
  localparam int unsigned LFSR_LEN = 16;

  logic                clk;
  logic                rst;
  logic                seed_load;
  logic [LFSR_LEN-1:0] seed;
  logic                start;
  logic                stop;
  logic                busy;
  logic                seed_err;
`ifdef KS_WORD_COUNT_EN
  logic [15:0]         ks_count;
`endif

  keystream_lfsr_gen_if #(.WIDTH(WIDTH)) ks_bus ();

  keystream_lfsr_gen #(
    .WIDTH    (WIDTH),
    .LFSR_LEN (LFSR_LEN),
    .TAPS     (16'hB400),
    .SEED_RST (16'h0001)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .start     (start),
    .stop      (stop),
    .ks        (ks_bus.master),
    .busy      (busy),
`ifdef KS_WORD_COUNT_EN
    .ks_count  (ks_count),
`endif
    .seed_err  (seed_err)
  );

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];

  // Hand-computed first five words from seed 16'h0001.
  logic [WIDTH-1:0] seed1_words [0:4];
  initial begin
    seed1_words[0] = 6'h01;
    seed1_words[1] = 6'h20;
    seed1_words[2] = 6'h16;
    seed1_words[3] = 6'h10;
    seed1_words[4] = 6'h14;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seed1(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(seed1_words[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every accepted word must match the queue head.
  always @(negedge clk) begin
    if (!rst && ks_bus.ks_valid && ks_bus.ks_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word: got 0x%0h expected no transfer", ks_bus.ks_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (ks_bus.ks_data !== e) begin
          failures++;
          $display("FAIL ks_word: got 0x%0h expected 0x%0h", ks_bus.ks_data, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

`ifdef KS_WORD_COUNT_EN
  logic [LFSR_LEN-1:0] m_lfsr;

  function automatic logic [WIDTH-1:0] model_word();
    logic [WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w[i]   = m_lfsr[0];
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
    return w;
  endfunction

  // Stream n words at full rate from the current model state, stop on the last.
  task automatic stream_model(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(model_word());
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < n - 1; i++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; seed_load = 1'b0; seed = '0; start = 1'b0; stop = 1'b0;
    ks_bus.ks_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", 32'(ks_bus.ks_valid), 32'd0);
    check("rst_data", 32'(ks_bus.ks_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_seed_err", 32'(seed_err), 32'd0);

    // Seed load with start, five words at full rate.
    push_seed1(5);
    seed_load = 1'b1; seed = 16'h0001; start = 1'b1; ks_bus.ks_ready = 1'b1;
    tick();
    seed_load = 1'b0; start = 1'b0;
    check("prime_valid_low", 32'(ks_bus.ks_valid), 32'd0);
    check("prime_busy", 32'(busy), 32'd1);
    tick();
    check("valid_latency", 32'(ks_bus.ks_valid), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t1_end_valid", 32'(ks_bus.ks_valid), 32'd0);
    check("t1_end_busy", 32'(busy), 32'd0);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Zero seed rejected; stream still starts from SEED_RST.
    do_reset();
    seed_load = 1'b1; seed = '0;
    tick();
    seed_load = 1'b0;
    check("seed_err_pulse", 32'(seed_err), 32'd1);
    tick();
    check("seed_err_clear", 32'(seed_err), 32'd0);
    check("seed_err_busy", 32'(busy), 32'd0);
    push_seed1(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: word and valid hold, then resume without a gap.
    do_reset();
    ks_bus.ks_ready = 1'b0;
    push_seed1(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(ks_bus.ks_valid), 32'd1);
      check("hold_data", 32'(ks_bus.ks_data), 32'h01);
      tick();
    end
    ks_bus.ks_ready = 1'b1;
    tick();
    check("nogap_valid", 32'(ks_bus.ks_valid), 32'd1);
    check("nogap_data", 32'(ks_bus.ks_data), 32'h20);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    ks_bus.ks_ready = 1'b0;
    check("t3_end_valid", 32'(ks_bus.ks_valid), 32'd0);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Stop under backpressure drains one word.
    do_reset();
    push_seed1(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("drain_busy", 32'(busy), 32'd1);
      check("drain_valid", 32'(ks_bus.ks_valid), 32'd1);
      check("drain_data", 32'(ks_bus.ks_data), 32'h01);
      tick();
    end
    ks_bus.ks_ready = 1'b1;
    tick();
    ks_bus.ks_ready = 1'b0;
    check("drain_end_valid", 32'(ks_bus.ks_valid), 32'd0);
    check("drain_end_busy", 32'(busy), 32'd0);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-stream drops the in-flight word; restart from SEED_RST.
    do_reset();
    push_seed1(1);
    ks_bus.ks_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    ks_bus.ks_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", 32'(ks_bus.ks_valid), 32'd0);
    check("midrst_data", 32'(ks_bus.ks_data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_seed_err", 32'(seed_err), 32'd0);
    push_seed1(2);
    ks_bus.ks_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef KS_WORD_COUNT_EN
    // Word counter: clear on seed load, count, wrap at 16'hFFFF.
    do_reset();
    check("cnt_rst", 32'(ks_count), 32'd0);
    ks_bus.ks_ready = 1'b1;
    seed_load = 1'b1; seed = 16'h0001;
    tick();
    seed_load = 1'b0;
    m_lfsr = 16'h0001;
    stream_model(10);
    check("cnt_ten", 32'(ks_count), 32'd10);
    stream_model(65525);
    check("cnt_max", 32'(ks_count), 32'hFFFF);
    stream_model(1);
    check("cnt_wrap", 32'(ks_count), 32'd0);
    seed_load = 1'b1; seed = 16'h0001;
    tick();
    seed_load = 1'b0;
    check("cnt_q_empty", 32'(exp_q.size()), 32'd0);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
